// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue with an RV32I decoder feeding a single issue register.
// A popped JAL redirects fetch one cycle later and squashes everything queued behind it.
module decode_queue #(
    parameter int IQ_DEPTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if2dec,
    input  logic [ADDR_WIDTH-1:0] pc_out,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic                  iq_full,
    input  logic                  flush_in,
    input  logic                  iss_ready,
    output logic                  iss_valid,
    output logic [3:0]            iss_class,
    output logic [3:0]            iss_funct,
    output logic [4:0]            iss_rd,
    output logic [4:0]            iss_rs1,
    output logic [4:0]            iss_rs2,
    output logic [31:0]           iss_imm,
    output logic [ADDR_WIDTH-1:0] iss_pc,
    output logic                  decFlush,
    output logic [ADDR_WIDTH-1:0] dec2if
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(IQ_DEPTH);

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OPIMM   = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    logic [ADDR_WIDTH-1:0] memPc   [IQ_DEPTH];
    logic [INST_WIDTH-1:0] memInst [IQ_DEPTH];

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  issValid_q, issValid_d;
    logic [3:0]            issClass_q, issClass_d;
    logic [3:0]            issFunct_q, issFunct_d;
    logic [4:0]            issRd_q, issRd_d, issRs1_q, issRs1_d, issRs2_q, issRs2_d;
    logic [31:0]           issImm_q, issImm_d;
    logic [ADDR_WIDTH-1:0] issPc_q, issPc_d;
    logic                  decFlush_q, decFlush_d;
    logic [ADDR_WIDTH-1:0] dec2if_q, dec2if_d;

    logic [ADDR_WIDTH-1:0] headPc;
    logic [INST_WIDTH-1:0] headInst;
    logic [3:0]            decClass, decFunct;
    logic [4:0]            decRd, decRs1, decRs2;
    logic [31:0]           decImm;
    logic                  flushNow, enq, pop, jalPop;

    assign headPc   = memPc[head_q];
    assign headInst = memInst[head_q];
    assign iq_full  = (count_q == FULL_COUNT);

    // Combinational RV32I decode of the queue head; fields absent from a format stay zero.
    always_comb begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immI, immS, immB, immU, immJ;
        opc  = headInst[6:0];
        f3   = headInst[14:12];
        f7   = headInst[31:25];
        immI = {{20{headInst[31]}}, headInst[31:20]};
        immS = {{20{headInst[31]}}, headInst[31:25], headInst[11:7]};
        immB = {{19{headInst[31]}}, headInst[31], headInst[7], headInst[30:25], headInst[11:8], 1'b0};
        immU = {headInst[31:12], 12'b0};
        immJ = {{11{headInst[31]}}, headInst[31], headInst[19:12], headInst[20], headInst[30:21], 1'b0};
        decClass = CLS_ILLEGAL;
        decRd    = 5'd0;
        decRs1   = 5'd0;
        decRs2   = 5'd0;
        decImm   = 32'd0;
        case (opc)
            7'b0110111: begin
                decClass = CLS_LUI;   decRd = headInst[11:7]; decImm = immU;
            end
            7'b0010111: begin
                decClass = CLS_AUIPC; decRd = headInst[11:7]; decImm = immU;
            end
            7'b1101111: begin
                decClass = CLS_JAL;   decRd = headInst[11:7]; decImm = immJ;
            end
            7'b1100111: begin
                if (f3 == 3'b000) begin
                    decClass = CLS_JALR; decRd = headInst[11:7]; decRs1 = headInst[19:15]; decImm = immI;
                end
            end
            7'b1100011: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    decClass = CLS_BRANCH; decRs1 = headInst[19:15]; decRs2 = headInst[24:20]; decImm = immB;
                end
            end
            7'b0000011: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    decClass = CLS_LOAD; decRd = headInst[11:7]; decRs1 = headInst[19:15]; decImm = immI;
                end
            end
            7'b0100011: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
                    decClass = CLS_STORE; decRs1 = headInst[19:15]; decRs2 = headInst[24:20]; decImm = immS;
                end
            end
            7'b0010011: begin
                if ((f3 == 3'b001 && f7 == 7'h00) ||
                    (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)) ||
                    (f3 != 3'b001 && f3 != 3'b101)) begin
                    decClass = CLS_OPIMM; decRd = headInst[11:7]; decRs1 = headInst[19:15]; decImm = immI;
                end
            end
            7'b0110011: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    decClass = CLS_OP; decRd = headInst[11:7]; decRs1 = headInst[19:15]; decRs2 = headInst[24:20];
                end
            end
            default: decClass = CLS_ILLEGAL;
        endcase
        decFunct = {headInst[30] & (decClass == CLS_OP || (decClass == CLS_OPIMM && f3 == 3'b101)), f3};
    end

    // Handshake qualifiers; a JAL pop or a pending redirect blocks the same-cycle enqueue.
    always_comb begin
        flushNow = rdy_in & flush_in;
        pop      = rdy_in & !flush_in & (count_q != '0) & (!issValid_q | iss_ready);
        jalPop   = pop & (decClass == CLS_JAL);
        enq      = rdy_in & if2dec & !iq_full & !flush_in & !decFlush_q & !jalPop;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        issValid_d = issValid_q;
        issClass_d = issClass_q;
        issFunct_d = issFunct_q;
        issRd_d    = issRd_q;
        issRs1_d   = issRs1_q;
        issRs2_d   = issRs2_q;
        issImm_d   = issImm_q;
        issPc_d    = issPc_q;
        decFlush_d = decFlush_q;
        dec2if_d   = dec2if_q;
        if (flushNow) begin
            head_d     = tail_q;
            count_d    = '0;
            issValid_d = 1'b0;
            decFlush_d = 1'b0;
        end else if (rdy_in) begin
            if (enq) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d     = head_q + 1'b1;
                issValid_d = 1'b1;
                issClass_d = decClass;
                issFunct_d = decFunct;
                issRd_d    = decRd;
                issRs1_d   = decRs1;
                issRs2_d   = decRs2;
                issImm_d   = decImm;
                issPc_d    = headPc;
            end else if (iss_ready) begin
                issValid_d = 1'b0;
            end
            if (enq && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !enq) begin
                count_d = count_q - 1'b1;
            end
            decFlush_d = jalPop;
            if (jalPop) begin
                head_d   = tail_q;
                count_d  = '0;
                dec2if_d = headPc + ADDR_WIDTH'(signed'(decImm));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            issValid_q <= 1'b0;
            issClass_q <= 4'd0;
            issFunct_q <= 4'd0;
            issRd_q    <= 5'd0;
            issRs1_q   <= 5'd0;
            issRs2_q   <= 5'd0;
            issImm_q   <= 32'd0;
            issPc_q    <= '0;
            decFlush_q <= 1'b0;
            dec2if_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            issValid_q <= issValid_d;
            issClass_q <= issClass_d;
            issFunct_q <= issFunct_d;
            issRd_q    <= issRd_d;
            issRs1_q   <= issRs1_d;
            issRs2_q   <= issRs2_d;
            issImm_q   <= issImm_d;
            issPc_q    <= issPc_d;
            decFlush_q <= decFlush_d;
            dec2if_q   <= dec2if_d;
        end
    end

    // Queue storage carries no reset; only the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (!rst_in && enq) begin
            memPc[tail_q]   <= pc_out;
            memInst[tail_q] <= inst_in;
        end
    end

    assign iss_valid = issValid_q;
    assign iss_class = issClass_q;
    assign iss_funct = issFunct_q;
    assign iss_rd    = issRd_q;
    assign iss_rs1   = issRs1_q;
    assign iss_rs2   = issRs2_q;
    assign iss_imm   = issImm_q;
    assign iss_pc    = issPc_q;
    assign decFlush  = decFlush_q;
    assign dec2if    = dec2if_q;

endmodule
